bus_delay_sched: RTL and testbench

Round-robin scheduler that shares one internal fixed-latency delay pipeline between NUM_REQ requesters. It grants at most one beat per cycle into the pipeline and tags each beat with its requester ID. Every beat is returned on a single output port exactly cur_delay cycles after acceptance. The delay is programmable at run time through a drain-and-apply state machine, so no in-flight beat is lost, duplicated or re-timed. It sits between the sync-aggregation requesters and the downstream alignment logic.

---
 rtl/bus_delay_sched.sv | 183 ++++++++++++++++++
 tb/tb_bus_delay_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_delay_sched.sv
// bus_delay_sched
// Round-robin scheduler feeding one shared fixed-latency delay pipeline.
// Each accepted beat is tagged with its requester ID and returned on a
// single output exactly cur_delay cycles after acceptance. The delay is
// changed at run time by draining the pipeline and then applying it, so
// in-flight beats keep their original timing.
//
// Optional feature macro: BUS_DELAY_SCHED_STAT_EN (saturating beat counter).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_data  per-requester beats (lane i at [i*BUS_WIDTH +: BUS_WIDTH])
//   req_ready           one-hot grant (combinational)
//   cfg_delay/cfg_load  requested delay and single-cycle load strobe
//   cfg_busy            high in DRAIN or APPLY
//   cur_delay           delay currently in effect
//   out_valid/out_id/out_data  returned beat
//   beat_cnt            accepted-beat count (0 when statistics are disabled)
//
// state | meaning
// RUN   | arbitrating, beats accepted into stage 0
// DRAIN | no grants; wait until stages 0..cur_delay-1 are empty
// APPLY | load new delay, clear all stage valids, back to RUN
`timescale 1ns/1ps
module bus_delay_sched #(
  parameter int NUM_REQ   = 4,
  parameter int BUS_WIDTH = 8,
  parameter int MAX_DELAY = 8,
  parameter int DEF_DELAY = 3,
  parameter int DLY_W     = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [DLY_W-1:0]             cfg_delay,
  input  logic                         cfg_load,
  output logic                         cfg_busy,
  output logic [DLY_W-1:0]             cur_delay,
  output logic                         out_valid,
  output logic [$clog2(NUM_REQ)-1:0]   out_id,
  output logic [BUS_WIDTH-1:0]         out_data,
  output logic [15:0]                  beat_cnt
);

  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;

  logic [1:0]           state;
  logic [DLY_W-1:0]     pend_delay;
  logic [DLY_W-1:0]     load_delay;
  logic [ID_W-1:0]      last_gnt;

  logic [MAX_DELAY-1:0] stg_valid;
  logic [ID_W-1:0]      stg_id   [MAX_DELAY];
  logic [BUS_WIDTH-1:0] stg_data [MAX_DELAY];

  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      gnt_id;
  logic [BUS_WIDTH-1:0] gnt_data;
  logic                 found;
  logic                 accept;
  logic                 drain_empty;

  // Search starts one past the last grant and wraps.
  always_comb begin
    gnt      = '0;
    gnt_id   = '0;
    gnt_data = '0;
    found    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[(int'(last_gnt) + k) % NUM_REQ]) begin
        found = 1'b1;
        gnt[(int'(last_gnt) + k) % NUM_REQ] = 1'b1;
        gnt_id   = ID_W'((int'(last_gnt) + k) % NUM_REQ);
        gnt_data = req_data[((int'(last_gnt) + k) % NUM_REQ)*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // No grant in the cfg_load cycle so nothing enters at the old delay
  // after the drain decision is made.
  assign req_ready = (state == ST_RUN && !cfg_load && !rst) ? gnt : '0;
  assign accept    = |req_ready;
  assign cfg_busy  = (state != ST_RUN);

  always_comb begin
    load_delay = cfg_delay;
    if (cfg_delay == '0)
      load_delay = DLY_W'(1);
    else if (cfg_delay > DLY_W'(MAX_DELAY))
      load_delay = DLY_W'(MAX_DELAY);
  end

  // Only stages that can still reach the output at the current delay matter.
  always_comb begin
    drain_empty = 1'b1;
    for (int i = 0; i < MAX_DELAY; i++)
      if (DLY_W'(i) < cur_delay && stg_valid[i])
        drain_empty = 1'b0;
  end

  always_comb begin
    out_valid = 1'b0;
    out_id    = '0;
    out_data  = '0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (cur_delay == DLY_W'(i + 1) && stg_valid[i]) begin
        out_valid = 1'b1;
        out_id    = stg_id[i];
        out_data  = stg_data[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      pend_delay <= DLY_W'(DEF_DELAY);
      cur_delay  <= DLY_W'(DEF_DELAY);
      last_gnt   <= ID_W'(NUM_REQ - 1);
    end else begin
      if (accept)
        last_gnt <= gnt_id;
      case (state)
        ST_RUN: begin
          if (cfg_load) begin
            pend_delay <= load_delay;
            state      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_empty)
            state <= ST_APPLY;
        end
        ST_APPLY: begin
          cur_delay <= pend_delay;
          state     <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid <= '0;
      for (int i = 0; i < MAX_DELAY; i++) begin
        stg_id[i]   <= '0;
        stg_data[i] <= '0;
      end
    end else begin
      stg_valid[0] <= accept;
      stg_id[0]    <= accept ? gnt_id : '0;
      stg_data[0]  <= accept ? gnt_data : '0;
      for (int i = 1; i < MAX_DELAY; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_id[i]    <= stg_id[i-1];
        stg_data[i]  <= stg_data[i-1];
      end
      // Beats parked beyond the old delay would otherwise surface at the
      // new one as stale duplicates.
      if (state == ST_APPLY)
        stg_valid <= '0;
    end
  end

`ifdef BUS_DELAY_SCHED_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      beat_cnt <= '0;
    else if (accept && beat_cnt != 16'hFFFF)
      beat_cnt <= beat_cnt + 16'd1;
  end
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_delay_sched.sv
`timescale 1ns/1ps
module tb_bus_delay_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [5:0]  cfg_delay;
  logic        cfg_load;
  logic        cfg_busy;
  logic [5:0]  cur_delay;
  logic        out_valid;
  logic [1:0]  out_id;
  logic [7:0]  out_data;
  logic [15:0] beat_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_delay_sched #(
    .NUM_REQ(4), .BUS_WIDTH(8), .MAX_DELAY(8), .DEF_DELAY(3), .DLY_W(6)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cfg_delay(cfg_delay), .cfg_load(cfg_load), .cfg_busy(cfg_busy),
    .cur_delay(cur_delay),
    .out_valid(out_valid), .out_id(out_id), .out_data(out_data),
    .beat_cnt(beat_cnt)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0; req_data = '0; cfg_delay = '0; cfg_load = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111; req_data = 32'hFFFF_FFFF; cfg_delay = 6'd5; cfg_load = 1'b1;
    #2;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", cfg_busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_id !== 2'd0 || out_data !== 8'h00) begin failures++; $display("FAIL reset_out_id_data got=%0d/%h exp=0/00", out_id, out_data); end
    checks++; if (cur_delay !== 6'd3) begin failures++; $display("FAIL reset_cur_delay got=%0d exp=3", cur_delay); end
    checks++; if (beat_cnt !== 16'd0) begin failures++; $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); end
    apply_reset();
  endtask

  task automatic test_single();
    logic exp_ov;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      req_valid = (k == 1) ? 4'b0100 : 4'b0000;
      req_data  = (k == 1) ? 32'h00A5_0000 : 32'h0;
      #1;
      if (k == 1) begin
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
      end
      exp_ov = (k == 4);
      checks++; if (out_valid !== exp_ov) begin failures++; $display("FAIL single_out_valid k=%0d got=%b exp=%b", k, out_valid, exp_ov); end
      if (k == 4) begin
        checks++; if (out_id !== 2'd2 || out_data !== 8'hA5) begin failures++; $display("FAIL single_out_beat got=%0d/%h exp=2/a5", out_id, out_data); end
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_id;
    apply_reset();
    req_data = 32'hC3C2_C1C0;
    for (int k = 0; k < 12; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      exp_rdy = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, exp_rdy); end
      exp_ov = (k >= 3 && k < 11);
      checks++; if (out_valid !== exp_ov) begin failures++; $display("FAIL rr_out_valid k=%0d got=%b exp=%b", k, out_valid, exp_ov); end
      if (exp_ov) begin
        exp_id = 2'((k - 3) % 4);
        checks++; if (out_id !== exp_id || out_data !== {6'b110000, exp_id}) begin failures++; $display("FAIL rr_out_beat k=%0d got=%0d/%h exp=%0d/%h", k, out_id, out_data, exp_id, {6'b110000, exp_id}); end
      end
      next_cycle();
    end
`ifdef BUS_DELAY_SCHED_STAT_EN
    checks++; if (beat_cnt !== 16'd8) begin failures++; $display("FAIL rr_beat_cnt got=%0d exp=8", beat_cnt); end
`else
    checks++; if (beat_cnt !== 16'd0) begin failures++; $display("FAIL rr_beat_cnt got=%0d exp=0", beat_cnt); end
`endif
  endtask

  task automatic test_rr_skip();
    logic [3:0] vin [7];
    logic [3:0] exp [7];
    vin = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1011, 4'b1011, 4'b1011};
    exp = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    apply_reset();
    req_data = 32'h4433_2211;
    for (int k = 0; k < 7; k++) begin
      req_valid = vin[k];
      #1;
      checks++; if (req_ready !== exp[k]) begin failures++; $display("FAIL skip_ready k=%0d got=%b exp=%b", k, req_ready, exp[k]); end
      next_cycle();
    end
    req_valid = '0;
  endtask

  task automatic test_delay_change();
    logic [3:0] exp_rdy;
    logic       exp_busy;
    logic [5:0] exp_cur;
    logic       exp_ov;
    logic [7:0] exp_dat;
    apply_reset();
    for (int k = 0; k < 18; k++) begin
      req_valid = (k <= 8) ? 4'b0001 : 4'b0000;
      case (k)
        0: req_data = 32'h11;
        1: req_data = 32'h22;
        2: req_data = 32'h33;
        default: req_data = 32'h44;
      endcase
      cfg_load  = (k == 3);
      cfg_delay = 6'd6;
      #1;
      exp_rdy  = (k <= 2 || k == 8) ? 4'b0001 : 4'b0000;
      exp_busy = (k >= 4 && k <= 7);
      exp_cur  = (k <= 7) ? 6'd3 : 6'd6;
      exp_ov   = (k == 3 || k == 4 || k == 5 || k == 14);
      case (k)
        3: exp_dat = 8'h11;
        4: exp_dat = 8'h22;
        5: exp_dat = 8'h33;
        default: exp_dat = 8'h44;
      endcase
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL dly_ready k=%0d got=%b exp=%b", k, req_ready, exp_rdy); end
      checks++; if (cfg_busy !== exp_busy) begin failures++; $display("FAIL dly_busy k=%0d got=%b exp=%b", k, cfg_busy, exp_busy); end
      checks++; if (cur_delay !== exp_cur) begin failures++; $display("FAIL dly_cur k=%0d got=%0d exp=%0d", k, cur_delay, exp_cur); end
      checks++; if (out_valid !== exp_ov) begin failures++; $display("FAIL dly_out_valid k=%0d got=%b exp=%b", k, out_valid, exp_ov); end
      if (exp_ov) begin
        checks++; if (out_id !== 2'd0 || out_data !== exp_dat) begin failures++; $display("FAIL dly_out_beat k=%0d got=%0d/%h exp=0/%h", k, out_id, out_data, exp_dat); end
      end
      next_cycle();
    end
    cfg_load = 1'b0;
  endtask

  task automatic test_clamp();
    logic       exp_busy;
    logic [5:0] exp_cur;
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      cfg_load  = (k == 0 || k == 1 || k == 4 || k == 6);
      cfg_delay = (k == 0) ? 6'd0 : (k == 6) ? 6'd2 : 6'd40;
      req_valid = (k == 3) ? 4'b0010 : 4'b0000;
      req_data  = 32'h0000_5A00;
      #1;
      exp_busy = (k == 1 || k == 2 || k == 5 || k == 6);
      exp_cur  = (k <= 2) ? 6'd3 : (k <= 6) ? 6'd1 : 6'd8;
      checks++; if (cfg_busy !== exp_busy) begin failures++; $display("FAIL clamp_busy k=%0d got=%b exp=%b", k, cfg_busy, exp_busy); end
      checks++; if (cur_delay !== exp_cur) begin failures++; $display("FAIL clamp_cur k=%0d got=%0d exp=%0d", k, cur_delay, exp_cur); end
      if (k == 3) begin
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL clamp_ready got=%b exp=0010", req_ready); end
      end
      if (k == 4) begin
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 8'h5A) begin failures++; $display("FAIL clamp_d1_beat got=%b/%0d/%h exp=1/1/5a", out_valid, out_id, out_data); end
      end
      next_cycle();
    end
    cfg_load = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      req_valid = (k < 2) ? 4'b0001 : 4'b0000;
      req_data  = (k == 0) ? 32'h77 : 32'h88;
      cfg_load  = (k == 2);
      cfg_delay = 6'd6;
      next_cycle();
    end
    cfg_load = 1'b0;
    req_valid = '0;
    #1;
    checks++; if (cfg_busy !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h77) begin failures++; $display("FAIL mid_pre busy/valid/data got=%b/%b/%h exp=1/1/77", cfg_busy, out_valid, out_data); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_id !== 2'd0 || out_data !== 8'h00) begin failures++; $display("FAIL mid_rst_out got=%b/%0d/%h exp=0/0/00", out_valid, out_id, out_data); end
    checks++; if (cfg_busy !== 1'b0 || cur_delay !== 6'd3) begin failures++; $display("FAIL mid_rst_cfg got=%b/%0d exp=0/3", cfg_busy, cur_delay); end
    checks++; if (beat_cnt !== 16'd0) begin failures++; $display("FAIL mid_rst_beat_cnt got=%0d exp=0", beat_cnt); end
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++; if (out_valid !== 1'b0 || cfg_busy !== 1'b0 || cur_delay !== 6'd3) begin failures++; $display("FAIL mid_after k=%0d valid/busy/cur got=%b/%b/%0d exp=0/0/3", k, out_valid, cfg_busy, cur_delay); end
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_data = '0; cfg_delay = '0; cfg_load = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_rr_skip();
    test_delay_change();
    test_clamp();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
